// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-style bus arbiter.
package mips_bus_pkg;

  // Encoding matches the one-hot grant vector {OWN1, OWN0}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  localparam logic [BUS_DATA_W-1:0] ARB_ABORT_DATA = 32'h0;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Combinational round-robin choice between two requesters; win is one-hot.
module mips_bus_rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    // On a tie the master that did not win last time is preferred.
    if (req0 && req1) begin
      win = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for the single-slave memory bus.
// Optional stall abort enabled with MIPS_BUS_ARB_TIMEOUT_EN.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_ADDR_W-1:0] m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [BUS_DATA_W-1:0] m0_writedata,
  input  logic [BUS_BE_W-1:0]   m0_byteenable,
  output logic [BUS_DATA_W-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [BUS_ADDR_W-1:0] m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [BUS_DATA_W-1:0] m1_writedata,
  input  logic [BUS_BE_W-1:0]   m1_byteenable,
  output logic [BUS_DATA_W-1:0] m1_readdata,
  output logic                  m1_waitrequest,
  output logic [BUS_ADDR_W-1:0] s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [BUS_DATA_W-1:0] s_writedata,
  output logic [BUS_BE_W-1:0]   s_byteenable,
  input  logic [BUS_DATA_W-1:0] s_readdata,
  input  logic                  s_waitrequest,
  output logic [1:0]            grant,
  output logic                  timeout
);

  arb_state_t state, state_next;
  logic       last, last_next;
  logic       req0, req1, owner_req, abort;
  logic [1:0] win;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign grant     = {state == OWN1, state == OWN0};
  assign owner_req = (state == OWN0) ? req0 : ((state == OWN1) ? req1 : 1'b0);

  mips_bus_rr_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .win  (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b0;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt;

  assign abort = owner_req && s_waitrequest && (stall_cnt == CNT_LAST);

  // Counter is cleared while idle, so each ownership starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        stall_cnt <= '0;
      end else if (s_waitrequest) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (abort) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    last_next      = last;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    case (state)
      IDLE: begin
        if (win[0]) begin
          state_next = OWN0;
          last_next  = 1'b0;
        end else if (win[1]) begin
          state_next = OWN1;
          last_next  = 1'b1;
        end
      end
      OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest & ~abort;
        m0_readdata    = abort ? ARB_ABORT_DATA : s_readdata;
        // Withdrawal, completion and abort all release the bus.
        if (!req0 || !s_waitrequest || abort) state_next = IDLE;
      end
      OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest & ~abort;
        m1_readdata    = abort ? ARB_ABORT_DATA : s_readdata;
        if (!req1 || !s_waitrequest || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter with a behavioural byte-lane memory slave.
// Define MIPS_BUS_ARB_TIMEOUT_EN to also exercise the stall abort.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  localparam int TO_CYC = 16;
  localparam int BUDGET = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;
  logic        slave_stall;
  bit          mon_en;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [1:0]  exp_grant_q[$];

  always #5 clk = ~clk;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout(timeout)
  );

  // Memory slave: combinational read, byte-lane write at completion.
  assign s_waitrequest = slave_stall;
  assign s_readdata    = s_read ? mem[s_address[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (s_write && !s_waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (s_byteenable[i]) mem[s_address[9:2]][8*i +: 8] <= s_writedata[8*i +: 8];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] addr_of(input int idx);
    return 32'hBFC0_0000 | (32'(idx) << 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic mem_load(input int idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx[7:0]; pre_data = d; ref_mem[idx] = d;
    @(posedge clk); #1 pre_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input int n, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic master_idle(input int n);
    drive(n, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Holds the request until waitrequest is low, returns at the negedge after completion
  // with the request still asserted so the caller can chain or drop it.
  task automatic master_xact(input int n, input bit is_wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             output logic [31:0] rdata, output int cycles, output bit ok);
    logic wreq;
    drive(n, !is_wr, is_wr, a, d, be);
    ok = 1'b0; cycles = 0; rdata = 32'h0;
    while (!ok && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      wreq = (n == 0) ? m0_waitrequest : m1_waitrequest;
      if (!wreq) begin
        ok = 1'b1;
        rdata = (n == 0) ? m0_readdata : m1_readdata;
      end
    end
    if (ok) @(negedge clk);
    else master_idle(n);
  endtask

  task automatic master_checked(input int n, input bit is_wr, input int idx,
                                input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rdata, exp;
    int cyc;
    bit ok;
    if (is_wr) ref_mem[idx] = merge(ref_mem[idx], d, be);
    else if (n == 0) exp_q0.push_back(ref_mem[idx]);
    else exp_q1.push_back(ref_mem[idx]);
    master_xact(n, is_wr, addr_of(idx), d, be, rdata, cyc, ok);
    checks++;
    if (!is_wr) exp = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    else exp = 32'h0;
    if (!ok) begin
      errors++;
      $display("FAIL m%0d_done: no completion after %0d cycles (required within %0d)", n, cyc, BUDGET);
    end else if (!is_wr && rdata !== exp) begin
      errors++;
      $display("FAIL m%0d_rdata idx %0d: got %h expected %h", n, idx, rdata, exp);
    end
  endtask

  // Compares every new grant (rising out of idle) against the expected sequence.
  task automatic grant_monitor();
    logic [1:0] prev, exp;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en && grant != 2'b00 && prev == 2'b00) begin
        checks++;
        if (exp_grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_seq: got %b with no grant expected", grant);
        end else begin
          exp = exp_grant_q.pop_front();
          if (grant !== exp) begin
            errors++;
            $display("FAIL grant_seq: got %b expected %b", grant, exp);
          end
        end
      end
      prev = grant;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_grant_q_empty(input string tag);
    checks++;
    if (exp_grant_q.size() != 0) begin
      errors++;
      $display("FAIL %s_grants_left: %0d expected grants never seen (required 0)", tag, exp_grant_q.size());
      exp_grant_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m0_read = 1'b1;
    repeat (2) @(negedge clk);
    checks += 11;
    if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b expected 00", grant); end
    if (s_read !== 1'b0) begin errors++; $display("FAIL rst_s_read: got %b expected 0", s_read); end
    if (s_write !== 1'b0) begin errors++; $display("FAIL rst_s_write: got %b expected 0", s_write); end
    if (s_address !== 32'h0) begin errors++; $display("FAIL rst_s_address: got %h expected 0", s_address); end
    if (s_writedata !== 32'h0) begin errors++; $display("FAIL rst_s_wdata: got %h expected 0", s_writedata); end
    if (s_byteenable !== 4'h0) begin errors++; $display("FAIL rst_s_be: got %b expected 0000", s_byteenable); end
    if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b expected 1", m0_waitrequest); end
    if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait: got %b expected 1", m1_waitrequest); end
    if (m0_readdata !== 32'h0) begin errors++; $display("FAIL rst_m0_rdata: got %h expected 0", m0_readdata); end
    if (m1_readdata !== 32'h0) begin errors++; $display("FAIL rst_m1_rdata: got %h expected 0", m1_readdata); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    m0_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    drive(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF);
    @(negedge clk);
    checks += 7;
    if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    if (s_read !== 1'b1) begin errors++; $display("FAIL single_s_read: got %b expected 1", s_read); end
    if (s_address !== 32'hBFC0_0000) begin errors++; $display("FAIL single_s_addr: got %h expected bfc00000", s_address); end
    if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_m0_wait: got %b expected 0", m0_waitrequest); end
    if (m0_readdata !== 32'h2402_0005) begin errors++; $display("FAIL single_m0_rdata: got %h expected 24020005", m0_readdata); end
    if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL single_m1_wait: got %b expected 1", m1_waitrequest); end
    if (m1_readdata !== 32'h0) begin errors++; $display("FAIL single_m1_rdata: got %h expected 0", m1_readdata); end
    @(negedge clk);
    checks += 2;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", grant); end
    if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL single_m1_wait2: got %b expected 1", m1_waitrequest); end
    master_idle(0);
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [31:0] orig4, orig5;
    reset_pulse();
    orig4 = ref_mem[4];
    orig5 = ref_mem[5];
    mon_en = 1'b1;
    exp_grant_q.push_back(2'b10);
    exp_grant_q.push_back(2'b01);
    fork
      begin master_checked(0, 1'b1, 4, 32'hDEAD_BEEF, 4'b0011); master_idle(0); end
      begin master_checked(1, 1'b1, 5, 32'h1234_A5A5, 4'b1100); master_idle(1); end
    join
    checks += 2;
    if (mem[4] !== {orig4[31:16], 16'hBEEF}) begin
      errors++; $display("FAIL cont_be0011: got %h expected %h", mem[4], {orig4[31:16], 16'hBEEF});
    end
    if (mem[5] !== {16'h1234, orig5[15:0]}) begin
      errors++; $display("FAIL cont_be1100: got %h expected %h", mem[5], {16'h1234, orig5[15:0]});
    end
    exp_grant_q.push_back(2'b10);
    exp_grant_q.push_back(2'b01);
    fork
      begin master_checked(0, 1'b0, 4, 32'h0, 4'hF); master_idle(0); end
      begin master_checked(1, 1'b0, 5, 32'h0, 4'hF); master_idle(1); end
    join
    @(negedge clk);
    check_grant_q_empty("cont");
    mon_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    reset_pulse();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_grant_q.push_back(2'b10);
      exp_grant_q.push_back(2'b01);
    end
    fork
      begin
        for (int i = 0; i < 8; i++)
          master_checked(0, 1'($urandom_range(0, 1)), 16 + i, $urandom, 4'($urandom_range(1, 15)));
        master_idle(0);
      end
      begin
        for (int j = 0; j < 8; j++)
          master_checked(1, 1'($urandom_range(0, 1)), 32 + j, $urandom, 4'($urandom_range(1, 15)));
        master_idle(1);
      end
    join
    @(negedge clk);
    check_grant_q_empty("b2b");
    mon_en = 1'b0;
    for (int i = 16; i < 40; i++) begin
      if (i < 24 || i >= 32) begin
        checks++;
        if (mem[i] !== ref_mem[i]) begin
          errors++; $display("FAIL b2b_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    slave_stall = 1'b1;
    drive(0, 1'b1, 1'b0, addr_of(6), 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL wd_grant0: got %b expected 01", grant); end
    drive(1, 1'b1, 1'b0, addr_of(7), 32'h0, 4'hF);
    @(negedge clk);
    checks += 2;
    if (grant !== 2'b01) begin errors++; $display("FAIL wd_hold: got %b expected 01", grant); end
    if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL wd_m1_wait: got %b expected 1", m1_waitrequest); end
    master_idle(0);
    slave_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL wd_idle: got %b expected 00", grant); end
    @(negedge clk);
    checks += 3;
    if (grant !== 2'b10) begin errors++; $display("FAIL wd_grant1: got %b expected 10", grant); end
    if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL wd_m1_done: got %b expected 0", m1_waitrequest); end
    if (m1_readdata !== ref_mem[7]) begin errors++; $display("FAIL wd_m1_rdata: got %h expected %h", m1_readdata, ref_mem[7]); end
    @(negedge clk);
    master_idle(1);
    @(negedge clk);
  endtask

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rdata;
    int cyc;
    bit ok;
    slave_stall = 1'b1;
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL to_pre: got %b expected 0", timeout); end
    master_xact(0, 1'b0, addr_of(8), 32'h0, 4'hF, rdata, cyc, ok);
    master_idle(0);
    slave_stall = 1'b0;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL to_abort: no abort after %0d cycles (required %0d)", cyc, TO_CYC); end
    if (cyc != TO_CYC) begin errors++; $display("FAIL to_cycles: got %0d expected %0d", cyc, TO_CYC); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h expected 0", rdata); end
    if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout); end
    @(negedge clk);
    master_checked(1, 1'b0, 9, 32'h0, 4'hF);
    master_idle(1);
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout); end
  endtask
`endif

  task automatic test_reset_mid();
    slave_stall = 1'b1;
    drive(0, 1'b1, 1'b0, addr_of(1), 32'h0, 4'hF);
    @(negedge clk);
    checks += 2;
    if (grant !== 2'b01) begin errors++; $display("FAIL rm_grant: got %b expected 01", grant); end
    if (s_read !== 1'b1) begin errors++; $display("FAIL rm_s_read: got %b expected 1", s_read); end
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (s_read !== 1'b0) begin errors++; $display("FAIL rm_async_read: got %b expected 0", s_read); end
    if (grant !== 2'b00) begin errors++; $display("FAIL rm_async_grant: got %b expected 00", grant); end
    if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_async_wait: got %b expected 1", m0_waitrequest); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL rm_timeout: got %b expected 0", timeout); end
    master_idle(0);
    slave_stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    exp_grant_q.push_back(2'b10);
    exp_grant_q.push_back(2'b01);
    fork
      begin master_checked(0, 1'b0, 2, 32'h0, 4'hF); master_idle(0); end
      begin master_checked(1, 1'b0, 3, 32'h0, 4'hF); master_idle(1); end
    join
    @(negedge clk);
    check_grant_q_empty("rm");
    mon_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    pre_we = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;
    slave_stall = 1'b0;
    mon_en = 1'b0;
    master_idle(0);
    master_idle(1);
    fork
      grant_monitor();
    join_none
    mem_load(0, 32'h2402_0005);
    for (int i = 1; i < 64; i++) mem_load(i, $urandom);
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_withdraw();
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    checks += 2;
    if (exp_q0.size() != 0) begin errors++; $display("FAIL sb_q0_left: %0d entries (required 0)", exp_q0.size()); end
    if (exp_q1.size() != 0) begin errors++; $display("FAIL sb_q1_left: %0d entries (required 0)", exp_q1.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter for the Avalon-style memory bus used by `mips_cpu_bus` and `simple_memory`. Master 0 is the CPU bus port and master 1 is a secondary requester (program loader / DMA). The arbiter grants the single memory port to one master at a time with round-robin fairness, forwards the granted master's transaction unchanged, and stalls the other master with `waitrequest`. It sits between the CPU and memory in the top-level test harness.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: stall limit for a granted transaction; used only with the timeout feature.

Ports (N ∈ {0,1}):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset; the block is in reset while `reset` = 0.
- `mN_address` in 32: master N byte address.
- `mN_read` / `mN_write` in 1: master N request strobes; held until its `mN_waitrequest` = 0.
- `mN_writedata` in 32, `mN_byteenable` in 4: master N write payload and byte lanes.
- `mN_readdata` out 32: read data to master N.
- `mN_waitrequest` out 1: stall to master N.
- `s_address` out 32, `s_read` / `s_write` out 1, `s_writedata` out 32, `s_byteenable` out 4: slave-side request.
- `s_readdata` in 32, `s_waitrequest` in 1: slave response.
- `grant` out 2: one-hot current owner; 2'b00 = idle.
- `timeout` out 1: sticky abort flag; constant 0 when the feature is compiled out.

## Operation
- States: IDLE, OWN0, OWN1. `grant` = {OWN1, OWN0}.
- IDLE: request N is `mN_read | mN_write`. If only one master requests, go to its OWN state. If both request, grant the master other than `last` (round-robin pointer, reset 0, so master 1 wins the first tie). Set `last` ← winner on grant.
- OWNn: the `s_*` request outputs equal master n's inputs combinationally. `mn_waitrequest` = `s_waitrequest`, and `mn_readdata` = `s_readdata`. The other master gets `waitrequest` = 1 and `readdata` = 0.
- Completion happens at a rising edge in OWNn with (`s_read | s_write`) = 1 and `s_waitrequest` = 0. Next state is IDLE.
- A master that drops its request in OWN without completing also returns the block to IDLE next cycle.
- IDLE and in reset: `s_read` = `s_write` = 0, `s_address` / `s_writedata` = 0, `s_byteenable` = 4'b0000, both `mN_waitrequest` = 1, both `mN_readdata` = 0.
- `mN_read` and `mN_write` both high is illegal. The arbiter forwards both strobes unchanged and does not correct them.

## Timing
- Arbitration is registered. A request first seen in IDLE at edge k is forwarded to the slave from edge k onward (cycle k+1). This is one cycle of arbitration latency.
- Back-to-back transactions from one master each pay one IDLE cycle.
- Fairness under continuous contention: grants alternate 0/1. No master waits more than one other transaction.
- Reset mid-transaction: `s_read` / `s_write` drop immediately (asynchronously). State goes to IDLE, `last` = 0, `timeout` = 0.
- Request and completion on the same edge: the completing owner goes to IDLE. A new request is evaluated in IDLE on the following edge.

## Configuration
- `MIPS_BUS_ARB_TIMEOUT_EN` defined:
  - A counter (clog2(TIMEOUT_CYCLES) bits) resets on entry to OWN and increments each OWN cycle where `s_waitrequest` = 1.
  - When it reaches TIMEOUT_CYCLES−1 with `s_waitrequest` still 1, the transaction is aborted. The owner gets `waitrequest` = 0 and `readdata` = 32'h0 for that cycle, then the state goes to IDLE.
  - `timeout` is set and stays set until reset.
- Macro undefined: no counter, `timeout` tied to 0, and a stalled slave holds the grant indefinitely.

## Structure
- Package `mips_bus_pkg` holds:
  - `arb_state_t` enum (IDLE, OWN0, OWN1);
  - `BUS_ADDR_W` = 32, `BUS_DATA_W` = 32, `BUS_BE_W` = 4;
  - the abort read value constant `ARB_ABORT_DATA` = 32'h0.
- Sub-module `mips_bus_rr_pick`: combinational round-robin choice from (req0, req1, last) to a one-hot winner. It is reused by the future 4-master variant.

## Test plan
- Single master: m0 reads 0xBFC00000 from memory initialised with 0x24020005. `grant` = 01 one cycle after `m0_read`. `m0_readdata` = 0x24020005 with `m0_waitrequest` = 0. m1 sees `waitrequest` = 1 throughout.
- Contention from reset: m0 and m1 both request in the same cycle. m1 is granted first (`last` = 0), then m0. Both complete with correct data, and each write lands with its byteenable (e.g. be = 4'b0011 writes only the low half-word).
- Continuous contention, 8 transactions each: the `grant` sequence alternates 10, 01, 10, … and no transaction is lost or duplicated.
- Reset asserted (`reset` = 0) while in OWN0 with `s_waitrequest` held 1: `s_read` drops in the same cycle, `grant` = 00, and after release the first tie goes to m1.
- `MIPS_BUS_ARB_TIMEOUT_EN` with TIMEOUT_CYCLES = 16 and a slave that holds `waitrequest` high: the abort happens after 16 OWN cycles, the master sees `waitrequest` = 0 with `readdata` = 0, `timeout` = 1 stays sticky, and the next request is still served.
- Owner withdraws its request before completion: the state returns to IDLE next cycle and the pending other master is granted on the following edge.
